// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared register-file constants, the strobe-width helper and the write-request record (used by both the write port and the read mux)
package reg_file_pkg;
  localparam int NUM_REGS = 8;
  localparam int ADDR_W = 3;
  localparam int REG_W = 32;
  function automatic int strb_w(input int w);
    return w / 8;
  endfunction
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0] data;
    logic [REG_W/8-1:0] strb;
  } wr_req_t;
endpackage

// File: rtl/reg_write_port_if.sv
// reg_write_port_if: write-request bus; master drives wr_valid_i/wr_addr_i/wr_data_i/wr_strb_i/hold_i, slave returns wr_ready_o
interface reg_write_port_if import reg_file_pkg::*; #(parameter int W_width = 32);
  logic wr_valid_i;
  logic wr_ready_o;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [W_width-1:0] wr_data_i;
  logic [W_width/8-1:0] wr_strb_i;
  logic hold_i;
  modport master (output wr_valid_i, wr_addr_i, wr_data_i, wr_strb_i, hold_i, input wr_ready_o);
  modport slave (input wr_valid_i, wr_addr_i, wr_data_i, wr_strb_i, hold_i, output wr_ready_o);
endinterface

// File: rtl/wr_fifo2.sv
// wr_fifo2: 2-entry FIFO of write requests; ports clk_i, rst_i (async high), push, pop, din in; head (oldest entry), count (0..2) out; caller never pushes when full or pops when empty
module wr_fifo2 import reg_file_pkg::*; #(parameter type T = wr_req_t) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push,
  input  logic       pop,
  input  T           din,
  output T           head,
  output logic [1:0] count
);
  T mem [2];
  logic wp, rp;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      wp <= wp ^ push;
      rp <= rp ^ pop;
      count <= count + 2'(push) - 2'(pop);
    end
  always_ff @(posedge clk_i)
    if (push) mem[wp] <= din;
  assign head = mem[rp];
endmodule

// File: rtl/reg_write_port.sv
// reg_write_port: queued byte-strobed write side of the 8-entry register file; ports clk_i, rst_i (async high), bus (write handshake + hold_i), R0_o..R7_o register contents, wr_en_o one-hot commit pulse, pending_o queued count
module reg_write_port import reg_file_pkg::*; #(
  parameter int W_width = 32,
  parameter logic [W_width-1:0] RST_VAL = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  reg_write_port_if.slave    bus,
  output logic [W_width-1:0] R0_o,
  output logic [W_width-1:0] R1_o,
  output logic [W_width-1:0] R2_o,
  output logic [W_width-1:0] R3_o,
  output logic [W_width-1:0] R4_o,
  output logic [W_width-1:0] R5_o,
  output logic [W_width-1:0] R6_o,
  output logic [W_width-1:0] R7_o,
  output logic [NUM_REGS-1:0] wr_en_o,
  output logic [1:0]         pending_o
);
  localparam int SW = strb_w(W_width);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [W_width-1:0] data;
    logic [SW-1:0] strb;
  } req_t;
  req_t din, head;
  logic push, pop;
  logic [W_width-1:0] merged;
  logic [W_width-1:0] regs [NUM_REGS];
  assign din = '{addr: bus.wr_addr_i, data: bus.wr_data_i, strb: bus.wr_strb_i};
  // ready reflects only the count, so a full buffer refuses even when it pops this cycle
  assign bus.wr_ready_o = pending_o != 2'd2;
  assign push = bus.wr_valid_i && bus.wr_ready_o;
  assign pop = pending_o != 2'd0 && !bus.hold_i;
  assign wr_en_o = pop ? NUM_REGS'(1) << head.addr : '0;
  wr_fifo2 #(.T(req_t)) u_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push(push),
    .pop(pop),
    .din(din),
    .head(head),
    .count(pending_o)
  );
  always_comb begin
    merged = regs[head.addr];
    for (int b = 0; b < SW; b++)
      merged[8*b +: 8] = head.strb[b] ? head.data[8*b +: 8] : regs[head.addr][8*b +: 8];
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RST_VAL;
    end else if (pop) begin
      regs[head.addr] <= merged;
    end
  assign R0_o = regs[0];
  assign R1_o = regs[1];
  assign R2_o = regs[2];
  assign R3_o = regs[3];
  assign R4_o = regs[4];
  assign R5_o = regs[5];
  assign R6_o = regs[6];
  assign R7_o = regs[7];
endmodule

// File: tb/tb_reg_write_port.sv
// tb_reg_write_port: directed vector table plus hand sequences for streaming and mid-run reset of reg_write_port
module tb_reg_write_port;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] r [8];
  logic [7:0] wr_en;
  logic [1:0] pending;
  int n_cmp = 0;
  int n_bad = 0;
  reg_write_port_if #(.W_width(32)) bus ();
  reg_write_port #(.W_width(32), .RST_VAL(32'h0)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus),
    .R0_o(r[0]),
    .R1_o(r[1]),
    .R2_o(r[2]),
    .R3_o(r[3]),
    .R4_o(r[4]),
    .R5_o(r[5]),
    .R6_o(r[6]),
    .R7_o(r[7]),
    .wr_en_o(wr_en),
    .pending_o(pending)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic v;
    logic [2:0] a;
    logic [31:0] d;
    logic [3:0] s;
    logic h;
    logic rdy;
    logic [1:0] pend;
    logic [7:0] en;
    int ri;
    logic [31:0] rv;
  } vec_t;
  vec_t tv [24];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [2:0] a, input logic [31:0] d, input logic [3:0] s, input logic h);
    bus.wr_valid_i = v;
    bus.wr_addr_i = a;
    bus.wr_data_i = d;
    bus.wr_strb_i = s;
    bus.hold_i = h;
  endtask
  initial begin
    //            v  a  data          strb  h  rdy pend en     ri rv
    tv[0]  = '{1, 5, 32'hDEADBEEF, 4'hF, 0, 1, 0, 8'h00, 5, 32'h0};
    tv[1]  = '{0, 0, 32'h0,        4'h0, 0, 1, 1, 8'h20, 5, 32'h0};
    tv[2]  = '{0, 0, 32'h0,        4'h0, 0, 1, 0, 8'h00, 5, 32'hDEADBEEF};
    tv[3]  = '{1, 2, 32'h11223344, 4'hF, 0, 1, 0, 8'h00, 2, 32'h0};
    tv[4]  = '{1, 2, 32'hAABBCCDD, 4'h5, 0, 1, 1, 8'h04, 2, 32'h0};
    tv[5]  = '{1, 2, 32'hFFFFFFFF, 4'h0, 0, 1, 1, 8'h04, 2, 32'h11223344};
    tv[6]  = '{0, 0, 32'h0,        4'h0, 0, 1, 1, 8'h04, 2, 32'h11BB33DD};
    tv[7]  = '{0, 0, 32'h0,        4'h0, 0, 1, 0, 8'h00, 2, 32'h11BB33DD};
    tv[8]  = '{1, 1, 32'h01010101, 4'hF, 1, 1, 0, 8'h00, 1, 32'h0};
    tv[9]  = '{1, 3, 32'h03030303, 4'hF, 1, 1, 1, 8'h00, 1, 32'h0};
    tv[10] = '{1, 4, 32'h00000044, 4'hF, 1, 0, 2, 8'h00, 1, 32'h0};
    tv[11] = '{1, 4, 32'h00000044, 4'hF, 0, 0, 2, 8'h02, 1, 32'h0};
    tv[12] = '{1, 4, 32'h00000044, 4'hF, 0, 1, 1, 8'h08, 1, 32'h01010101};
    tv[13] = '{0, 0, 32'h0,        4'h0, 0, 1, 1, 8'h10, 3, 32'h03030303};
    tv[14] = '{0, 0, 32'h0,        4'h0, 0, 1, 0, 8'h00, 4, 32'h00000044};
    tv[15] = '{1, 7, 32'h00000001, 4'hF, 0, 1, 0, 8'h00, 7, 32'h0};
    tv[16] = '{1, 7, 32'h00000002, 4'hF, 0, 1, 1, 8'h80, 7, 32'h0};
    tv[17] = '{1, 7, 32'h00000003, 4'hF, 0, 1, 1, 8'h80, 7, 32'h1};
    tv[18] = '{0, 0, 32'h0,        4'h0, 0, 1, 1, 8'h80, 7, 32'h2};
    tv[19] = '{0, 0, 32'h0,        4'h0, 0, 1, 0, 8'h00, 7, 32'h3};
    tv[20] = '{1, 0, 32'hCAFEBABE, 4'hC, 0, 1, 0, 8'h00, 0, 32'h0};
    tv[21] = '{0, 0, 32'h0,        4'h0, 0, 1, 1, 8'h01, 0, 32'h0};
    tv[22] = '{0, 0, 32'h0,        4'h0, 0, 1, 0, 8'h00, 0, 32'hCAFE0000};
    tv[23] = '{0, 0, 32'h0,        4'h0, 0, 1, 0, 8'h00, 5, 32'hDEADBEEF};
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("reset_R%0d", i), r[i], 32'h0);
    chk("reset_pending", 32'(pending), 32'd0);
    chk("reset_ready", 32'(bus.wr_ready_o), 32'd1);
    chk("reset_wr_en", 32'(wr_en), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      drive(tv[i].v, tv[i].a, tv[i].d, tv[i].s, tv[i].h);
      #1;
      chk($sformatf("v%0d_ready", i), 32'(bus.wr_ready_o), 32'(tv[i].rdy));
      chk($sformatf("v%0d_pending", i), 32'(pending), 32'(tv[i].pend));
      chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(tv[i].en));
      chk($sformatf("v%0d_R%0d", i, tv[i].ri), r[tv[i].ri], tv[i].rv);
      @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1, 3'(i), 32'h11111111 * (i + 1), 4'hF, 0);
      #1;
      chk($sformatf("stream%0d_pending", i), 32'(pending), i == 0 ? 32'd0 : 32'd1);
      chk($sformatf("stream%0d_wr_en", i), 32'(wr_en), i == 0 ? 32'd0 : 32'(8'h01 << (i - 1)));
      @(negedge clk);
    end
    drive(0, 0, 0, 0, 0);
    #1;
    chk("stream_tail_wr_en", 32'(wr_en), 32'h80);
    @(negedge clk);
    for (int i = 0; i < 8; i++) chk($sformatf("stream_R%0d", i), r[i], 32'h11111111 * (i + 1));
    drive(1, 6, 32'h66666666, 4'hF, 1);
    @(negedge clk);
    drive(1, 6, 32'h77777777, 4'hF, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0);
    #1;
    chk("prereset_pending", 32'(pending), 32'd2);
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) chk($sformatf("midreset_R%0d", i), r[i], 32'h0);
    chk("midreset_pending", 32'(pending), 32'd0);
    chk("midreset_ready", 32'(bus.wr_ready_o), 32'd1);
    chk("midreset_wr_en", 32'(wr_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("postreset%0d_wr_en", k), 32'(wr_en), 32'd0);
      chk($sformatf("postreset%0d_R6", k), r[6], 32'h0);
      @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
